mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Multi-cycle sequencer between the core datapath and data memory for all RISC-V load/store instructions (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Takes the decoded access request, effective address (ALU result) and rs2 data.
- Runs a req/ack handshake with data memory.
- Generates byte enables, store-lane replication, load-lane extraction and sign/zero extension.
- Stalls the PC/register writeback until the access completes or faults.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in REQ without memAck before a timeout fault (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
memRead  input  1  load request from control; held until done or err
memWrite  input  1  store request from control; held until done or err
funct3  input  3  instruction funct3 (access size/signedness)
addr  input  32  effective byte address from ALU
storeData  input  32  rs2 value for stores
stall  output  1  hold PC and suppress regfile write
done  output  1  one-cycle pulse: access completed
err  output  1  one-cycle pulse: access faulted
errCode  output  2  01 misaligned, 10 illegal request, 11 timeout; valid while err=1
loadData  output  32  extended load result; valid from done pulse until the next load completes
memReq  output  1  memory request, held until memAck
memWe  output  1  1 = write, valid with memReq
memAddr  output  32  word address {addr[31:2],2'b00}
memWdata  output  32  lane-replicated store data
memByteEn  output  4  byte-lane enables
memRdata  input  32  memory read word, valid with memAck
memAck  input  1  memory completes transfer (sampled only in REQ)

Behaviour:
- Reset (rst=1 at clock edge):
  - State goes to IDLE.
  - memReq, memWe, done, err, errCode, memByteEn, memWdata, memAddr and loadData are all 0.
  - Reset during REQ abandons the transfer; memReq is low from the next cycle.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - If memRead or memWrite is high, latch addr, funct3, storeData and the direction.
  - Then check the request:
    - Both memRead and memWrite high -> ERR, code 10.
    - Load funct3 not in {000,001,010,100,101}, or store funct3 not in {000,001,010} -> ERR, code 10.
    - Halfword with addr[0]=1, or word with addr[1:0]!=0 -> ERR, code 01.
    - Otherwise -> REQ.
- REQ:
  - memReq=1; memWe, memAddr, memByteEn and memWdata are registered and stable for the whole state.
  - memAck=1 -> DONE; for loads, loadData is captured from memRdata on that edge.
  - Cycle counter counts from 0. If count = TIMEOUT_CYCLES-1 and memAck=0 -> ERR, code 11.
  - Ack on the final cycle wins over timeout.
- DONE: done=1 for one cycle, memReq=0 -> IDLE.
- ERR: err=1 for one cycle, errCode valid, memReq=0 -> IDLE. loadData is unchanged.
- stall is combinational:
  - 1 in IDLE when memRead|memWrite is high, and throughout REQ.
  - 0 in DONE, ERR, and IDLE with no request.
- Request inputs are ignored in REQ, DONE and ERR. A request still held in the IDLE cycle after DONE/ERR starts a new access, so the requester must drop it when it sees done/err.
- memAck outside REQ is ignored.
- Byte enables:
  - SB: 0001<<addr[1:0]
  - SH: 0011<<{addr[1],1'b0}
  - SW: 1111
  - Loads: same masks (informational).
- Store data:
  - SB: {4{storeData[7:0]}}
  - SH: {2{storeData[15:0]}}
  - SW: storeData
  - memWdata is 0 for loads.
- Load extraction: byte lane = memRdata[8*addr[1:0] +: 8]; half lane = memRdata[16*addr[1] +: 16].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: full word.
- Latency with a zero-wait memory (ack in first REQ cycle): request seen at T, REQ at T+1, done at T+2; stall high for T and T+1.

Test Plan:
1. LW at addr 0x100, memAck in first REQ cycle, memRdata=0xDEADBEEF -> memAddr=0x100, memByteEn=1111, memWe=0; done at T+2; loadData=0xDEADBEEF; stall high exactly 2 cycles.
2. LB at 0x203 and LBU at 0x203, memRdata=0x80112233 -> memByteEn=1000; LB gives loadData=0xFFFFFF80, LBU gives 0x00000080.
3. SH at 0x302, storeData=0x1234ABCD, memAck after 3 REQ cycles -> memAddr=0x300, memWe=1, memByteEn=1100, memWdata=0xABCDABCD held stable 3 cycles; done pulse; loadData unchanged.
4. LH at 0x101 -> err pulse, errCode=01, memReq never asserted. memRead+memWrite together -> errCode=10. Store with funct3=100 -> errCode=10.
5. LW with memAck never asserted, TIMEOUT_CYCLES=16 -> memReq high exactly 16 cycles, then err with errCode=11, stall low. Repeat with ack on the 16th cycle -> done, no err.
6. rst pulsed during REQ -> memReq=0 and all outputs 0 next cycle; a later memAck is ignored; a fresh SW at 0x0 then completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the load/store sequencer (master) and data memory (slave).
// The request side holds memReq and its qualifiers stable until memAck.
interface mem_access_ctrl_if;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memByteEn;
    logic [31:0] memRdata;
    logic        memAck;

    modport master (
        output memReq, memWe, memAddr, memWdata, memByteEn,
        input  memRdata, memAck
    );

    modport slave (
        input  memReq, memWe, memAddr, memWdata, memByteEn,
        output memRdata, memAck
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// RISC-V load/store sequencer: validates the access, runs req/ack with data memory, aligns lanes.
// Zero-wait latency is 2 cycles (request -> REQ -> DONE); memory wait states stretch REQ up to TIMEOUT_CYCLES.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memRead,
    input  logic                     memWrite,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              storeData,
    output logic                     stall,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               errCode,
    output logic [31:0]              loadData,
    mem_access_ctrl_if.master        mem
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] load_q, load_d;

    logic        req_any;
    logic [1:0]  req_code;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    assign req_any = memRead | memWrite;

    // Decode of the live request; only consumed in the IDLE cycle that accepts it.
    always_comb begin
        req_code  = 2'b00;
        req_be    = 4'b1111;
        req_wdata = 32'h0;
        if (memRead && memWrite) begin
            req_code = 2'b10;
        end else if (memRead && !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
            req_code = 2'b10;
        end else if (memWrite && funct3[2:0] > 3'b010) begin
            req_code = 2'b10;
        end else if ((funct3[1:0] == 2'b01 && addr[0]) ||
                     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)) begin
            req_code = 2'b01;
        end
        unique case (funct3[1:0])
            2'b00:   req_be = 4'b0001 << addr[1:0];
            2'b01:   req_be = 4'b0011 << {addr[1], 1'b0};
            default: req_be = 4'b1111;
        endcase
        if (memWrite) begin
            unique case (funct3[1:0])
                2'b00:   req_wdata = {4{storeData[7:0]}};
                2'b01:   req_wdata = {2{storeData[15:0]}};
                default: req_wdata = storeData;
            endcase
        end
    end

    always_comb begin
        rd_byte = mem.memRdata[{lane_q, 3'b000} +: 8];
        rd_half = mem.memRdata[{lane_q[1], 4'b0000} +: 16];
        unique case (funct3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {24'h0, rd_byte};
            3'b101:  rd_ext = {16'h0, rd_half};
            default: rd_ext = mem.memRdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        code_d   = code_q;
        load_d   = load_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    lane_d   = addr[1:0];
                    funct3_d = funct3;
                    we_d     = memWrite;
                    addr_d   = {addr[31:2], 2'b00};
                    wdata_d  = req_wdata;
                    be_d     = req_be;
                    cnt_d    = 8'd0;
                    if (req_code != 2'b00) begin
                        code_d  = req_code;
                        state_d = ERR;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // An ack in the last allowed cycle takes priority over the timeout.
                if (mem.memAck) begin
                    if (!we_q) load_d = rd_ext;
                    state_d = DONE;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    code_d  = 2'b11;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            lane_q   <= 2'b00;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            code_q   <= 2'b00;
            load_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            code_q   <= code_d;
            load_q   <= load_d;
        end
    end

    assign mem.memReq    = (state_q == REQ);
    assign mem.memWe     = we_q;
    assign mem.memAddr   = addr_q;
    assign mem.memWdata  = wdata_q;
    assign mem.memByteEn = be_q;
    assign done          = (state_q == DONE);
    assign err           = (state_q == ERR);
    assign errCode       = code_q;
    assign loadData      = load_q;
    assign stall         = (state_q == REQ) || (state_q == IDLE && req_any);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized load/store accesses checked against a spec-level model of each access.
module tb_mem_access_ctrl;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, storeData;
    logic        stall, done, err;
    logic [1:0]  errCode;
    logic [31:0] loadData;
    logic [31:0] exp_load;

    int n_total = 0;
    int n_pass  = 0;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .funct3    (funct3),
        .addr      (addr),
        .storeData (storeData),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .errCode   (errCode),
        .loadData  (loadData),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    // Expected outcome of one access, derived from the ISA-level rules with plain arithmetic.
    task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                         output int code, output logic [31:0] be, output logic [31:0] wd,
                         output logic [31:0] ld);
        int idx, size;
        logic [31:0] sh, b, h;
        idx  = int'(a % 4);
        size = int'(f3 % 4);
        if (rd && wr)                                     code = 2;
        else if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) code = 2;
        else if (wr && f3 > 2)                            code = 2;
        else if (size == 1 && a % 2 != 0)                 code = 1;
        else if (size == 2 && a % 4 != 0)                 code = 1;
        else                                              code = 0;
        be = (size == 0) ? (32'd1 << idx) : (size == 1) ? (32'd3 << idx) : 32'd15;
        if (!wr)            wd = 32'h0;
        else if (size == 0) wd = (sd % 256) * 32'h01010101;
        else if (size == 1) wd = (sd % 65536) * 32'h00010001;
        else                wd = sd;
        sh = rdat >> (8 * idx);
        b  = sh % 256;
        h  = sh % 65536;
        case (f3)
            3'd0:    ld = (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1:    ld = (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    ld = b;
            3'd5:    ld = h;
            default: ld = rdat;
        endcase
    endtask

    // ack_at: REQ cycle index (0-based) on which memAck is given; -1 = never.
    task automatic run(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                       input int ack_at);
        int code;
        logic [31:0] be, wd, ld;
        model(rd, wr, f3, a, sd, rdat, code, be, wd, ld);
        @(negedge clk);
        memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = sd;
        #1;
        chk({tag, ".stall_idle"}, 32'(stall), 32'd1);
        chk({tag, ".req_idle"}, 32'(bus.memReq), 32'd0);
        @(negedge clk);
        if (code != 0) begin
            chk({tag, ".err"}, 32'(err), 32'd1);
            chk({tag, ".code"}, 32'(errCode), 32'(code));
            chk({tag, ".req_err"}, 32'(bus.memReq), 32'd0);
            chk({tag, ".stall_err"}, 32'(stall), 32'd0);
            memRead = 1'b0; memWrite = 1'b0;
        end else begin
            for (int k = 0; k < TO; k++) begin
                chk({tag, ".req"}, 32'(bus.memReq), 32'd1);
                chk({tag, ".stall_req"}, 32'(stall), 32'd1);
                chk({tag, ".we"}, 32'(bus.memWe), 32'(wr));
                chk({tag, ".addr"}, bus.memAddr, a & 32'hFFFFFFFC);
                chk({tag, ".be"}, 32'(bus.memByteEn), be);
                chk({tag, ".wdata"}, bus.memWdata, wd);
                if (k == ack_at) begin
                    bus.memAck = 1'b1; bus.memRdata = rdat;
                    @(negedge clk);
                    bus.memAck = 1'b0; bus.memRdata = $urandom;
                    memRead = 1'b0; memWrite = 1'b0;
                    if (rd) exp_load = ld;
                    chk({tag, ".done"}, 32'(done), 32'd1);
                    chk({tag, ".err_on_done"}, 32'(err), 32'd0);
                    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
                    chk({tag, ".load"}, loadData, exp_load);
                    break;
                end else if (k == TO - 1) begin
                    @(negedge clk);
                    memRead = 1'b0; memWrite = 1'b0;
                    chk({tag, ".to_err"}, 32'(err), 32'd1);
                    chk({tag, ".to_code"}, 32'(errCode), 32'd3);
                    chk({tag, ".to_req"}, 32'(bus.memReq), 32'd0);
                    chk({tag, ".to_stall"}, 32'(stall), 32'd0);
                end else begin
                    bus.memRdata = $urandom;
                    @(negedge clk);
                end
            end
        end
        chk({tag, ".load_kept"}, loadData, exp_load);
        @(negedge clk);
        chk({tag, ".idle_done"}, 32'(done), 32'd0);
        chk({tag, ".idle_err"}, 32'(err), 32'd0);
        chk({tag, ".idle_req"}, 32'(bus.memReq), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".req"}, 32'(bus.memReq), 32'd0);
        chk({tag, ".we"}, 32'(bus.memWe), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'd0);
        chk({tag, ".code"}, 32'(errCode), 32'd0);
        chk({tag, ".be"}, 32'(bus.memByteEn), 32'd0);
        chk({tag, ".wdata"}, bus.memWdata, 32'd0);
        chk({tag, ".addr"}, bus.memAddr, 32'd0);
        chk({tag, ".load"}, loadData, 32'd0);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        logic rd, wr;
        int   sel, ack;
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'd0;
        addr = 32'h0; storeData = 32'h0; exp_load = 32'h0;
        bus.memAck = 1'b0; bus.memRdata = 32'h0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        run("lw",   1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run("lb",   1, 0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0);
        run("lbu",  1, 0, 3'b100, 32'h203, 32'h0, 32'h80112233, 1);
        run("sh",   0, 1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 2);
        run("lh_mis", 1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0);
        run("rw",   1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0);
        run("s100", 0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        run("to",   1, 0, 3'b010, 32'h40, 32'h0, 32'h11112222, -1);
        run("ack16", 1, 0, 3'b010, 32'h44, 32'h0, 32'hCAFEF00D, TO - 1);

        // Reset in the middle of a transfer.
        @(negedge clk);
        memRead = 1'b1; funct3 = 3'b010; addr = 32'h80;
        @(negedge clk);
        chk("rstreq.req", 32'(bus.memReq), 32'd1);
        rst = 1'b1; memRead = 1'b0;
        @(negedge clk);
        exp_load = 32'h0;
        chk_zero("rstreq");
        rst = 1'b0; bus.memAck = 1'b1; bus.memRdata = 32'h55AA55AA;
        @(negedge clk);
        chk("late_ack.req", 32'(bus.memReq), 32'd0);
        chk("late_ack.done", 32'(done), 32'd0);
        bus.memAck = 1'b0;
        run("sw0", 0, 1, 3'b010, 32'h0, 32'h87654321, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel <= 5);
            wr  = (sel == 0) || (sel >= 6);
            ack = (i % 13 == 5) ? -1 : int'($urandom_range(0, 3));
            run("rand", rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, ack);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
